// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM receive path: duty scale and the two small state
// encodings used by the decoder's measurement FSM and divider.
package pwm_pkg;

  localparam int unsigned DUTY_STEPS_DEFAULT = 10;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t WAIT_EDGE = 1'b0;
  localparam fsm_state_t MEASURE   = 1'b1;

  typedef logic [0:0] div_state_t;
  localparam div_state_t DIV_IDLE = 1'b0;
  localparam div_state_t DIV_RUN  = 1'b1;

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: 2-flop synchroniser, optional glitch filter, rising-edge detector.
// Build option: PWM_DEC_GLITCH_FILTER_EN enables the FILTER_LEN-sample stability filter.
module pwm_in_sync
`ifdef PWM_DEC_GLITCH_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 3
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level_o,
  output logic rise_o
);

  logic s_meta, s_q, s_qq, filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      s_meta <= pwm_in;
      s_q    <= s_meta;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] fcnt_q;
  logic           filt_q;

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (s_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= s_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_qq <= 1'b0;
    end else begin
      s_qq <= filt;
    end
  end

  assign level_o = filt;
  assign rise_o  = filt & ~s_qq;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive decoder: measures period and high time between rising edges and reports duty
// on a DUTY_STEPS scale. Build option: PWM_DEC_GLITCH_FILTER_EN adds an input glitch filter.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DUTY_STEPS = DUTY_STEPS_DEFAULT,
  parameter int unsigned DUTY_W     = 4,
  parameter int unsigned TIMEOUT    = 1000
`ifdef PWM_DEC_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              valid_o,
  output logic              stuck_o,
  output logic              overrun_o
);

  localparam int unsigned      ACC_W   = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic level, rise;

`ifdef PWM_DEC_GLITCH_FILTER_EN
  pwm_in_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
`else
  pwm_in_sync u_sync (
`endif
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level_o(level),
    .rise_o (rise)
  );

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  div_state_t        div_state_q, div_state_d;
  logic [DUTY_W-1:0] div_iter_q, div_iter_d;
  logic [ACC_W-1:0]  div_acc_q, div_acc_d;
  logic [DUTY_W-1:0] div_q_q, div_q_d;
  logic [CNT_W-1:0]  div_per_q, div_per_d;
  logic [CNT_W-1:0]  div_high_q, div_high_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              overrun_q, overrun_d;

  logic [ACC_W-1:0]  acc_step;
  logic [DUTY_W-1:0] q_step;
  logic              div_last;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    div_state_d  = div_state_q;
    div_iter_d   = div_iter_q;
    div_acc_d    = div_acc_q;
    div_q_d      = div_q_q;
    div_per_d    = div_per_q;
    div_high_d   = div_high_q;
    period_d     = period_q;
    high_d       = high_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    overrun_d    = 1'b0;

    acc_step = div_acc_q;
    q_step   = div_q_q;
    if (div_acc_q >= ACC_W'(div_per_q)) begin
      acc_step = div_acc_q - ACC_W'(div_per_q);
      q_step   = div_q_q + 1'b1;
    end
    div_last = (div_state_q == DIV_RUN) && (div_iter_q == DUTY_W'(DUTY_STEPS - 1));

    if (div_state_q == DIV_RUN) begin
      div_acc_d  = acc_step;
      div_q_d    = q_step;
      div_iter_d = div_iter_q + 1'b1;
      if (div_last) begin
        div_state_d = DIV_IDLE;
        valid_d     = 1'b1;
        stuck_d     = 1'b0;
        period_d    = div_per_q;
        high_d      = div_high_q;
        duty_d      = q_step;
      end
    end

    unique case (state_q)
      WAIT_EDGE: begin
        if (rise) begin
          state_d      = MEASURE;
          period_cnt_d = CNT_W'(1);
          high_cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          period_cnt_d = CNT_W'(1);
          high_cnt_d   = CNT_W'(1);
          // A divider on its final iteration frees up this cycle, so back-to-back
          // DUTY_STEPS-cycle periods are all reported.
          if (div_state_q == DIV_IDLE || div_last) begin
            div_state_d = DIV_RUN;
            div_iter_d  = '0;
            div_acc_d   = ACC_W'(high_cnt_q) * ACC_W'(DUTY_STEPS);
            div_q_d     = '0;
            div_per_d   = period_cnt_q;
            div_high_d  = high_cnt_q;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (period_cnt_q >= CNT_W'(TIMEOUT)) begin
          state_d      = WAIT_EDGE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          div_state_d  = DIV_IDLE;
          valid_d      = 1'b1;
          stuck_d      = 1'b1;
          period_d     = '0;
          high_d       = '0;
          duty_d       = level ? DUTY_W'(DUTY_STEPS) : '0;
        end else begin
          if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + 1'b1;
          if (level && high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_EDGE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      div_state_q  <= DIV_IDLE;
      div_iter_q   <= '0;
      div_acc_q    <= '0;
      div_q_q      <= '0;
      div_per_q    <= '0;
      div_high_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      div_state_q  <= div_state_d;
      div_iter_q   <= div_iter_d;
      div_acc_q    <= div_acc_d;
      div_q_q      <= div_q_d;
      div_per_q    <= div_per_d;
      div_high_q   <= div_high_d;
      period_q     <= period_d;
      high_q       <= high_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign duty_o    = duty_q;
  assign valid_o   = valid_q;
  assign stuck_o   = stuck_q;
  assign overrun_o = overrun_q;

endmodule
